io_seq_checker: RTL and testbench

Synthesizable, parametrised successor to the harness-level GPIO pattern monitor. It watches a user-I/O bus (e.g. `mprj_io[7:0]`) for an ordered sequence of masked values, with a per-step timeout, and reports pass/fail plus the failing step. It sits beside the rapcore harness so on-chip self-test can run without a simulator `wait` chain. It is generalised in bus width, sequence depth, per-bit masking and stability filtering.

---
 rtl/io_seq_pkg.sv | 22 ++
 rtl/io_seq_checker_io_sync.sv | 26 ++
 rtl/io_seq_checker.sv | 152 +++++++++++++++
 tb/tb_io_seq_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and width helpers for the I/O sequence checker.
// State encoding is fixed so software and self-test logic can decode it.
package io_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Index width for a table of 'depth' entries (never narrower than 1 bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width able to hold the values 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/io_seq_checker_io_sync.sv
// Two-flop synchronizer for the monitored bus; both stages clear on reset.
module io_sync #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge CLK) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/io_seq_checker.sv
// Watches a synchronized I/O bus for an ordered list of masked values with a
// per-step timeout; reports pass, fail and the step that timed out.
module io_seq_checker
  import io_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT_W = 24,
  parameter int STABLE    = 2
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            io_in,
  input  logic                        wr_en,
  input  logic [addr_w(DEPTH)-1:0]    wr_addr,
  input  logic [WIDTH-1:0]            wr_value,
  input  logic [WIDTH-1:0]            wr_mask,
  input  logic [count_w(DEPTH)-1:0]   seq_len,
  input  logic [TIMEOUT_W-1:0]        timeout,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        pass,
  output logic                        fail,
  output logic [addr_w(DEPTH)-1:0]    fail_step,
  output logic [count_w(DEPTH)-1:0]   step,
  output logic                        match_pulse
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = count_w(DEPTH);
  localparam int STB_W  = count_w(STABLE);
  localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE - 1);

  logic [WIDTH-1:0] sync_io;

  io_sync #(.WIDTH(WIDTH)) u_sync (
    .CLK   (CLK),
    .reset (reset),
    .din   (io_in),
    .dout  (sync_io)
  );

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       step_reg, step_next;
  logic [CNT_W-1:0]       len_reg, len_next;
  logic [STB_W-1:0]       stable_reg, stable_next;
  logic [TIMEOUT_W-1:0]   tmo_reg, tmo_next;
  logic [TIMEOUT_W-1:0]   timeout_reg, timeout_next;
  logic [ADDR_W-1:0]      fail_step_reg, fail_step_next;
  logic                   pulse_reg, pulse_next;

  // Entry table: not cleared by reset, frozen while a check is running.
  logic [WIDTH-1:0] value_mem [DEPTH];
  logic [WIDTH-1:0] mask_mem  [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en && (state_reg != ST_RUN)) begin
      value_mem[wr_addr] <= wr_value;
      mask_mem[wr_addr]  <= wr_mask;
    end
  end

  logic [ADDR_W-1:0]    rd_idx;
  logic                 step_match;
  logic                 accept;
  logic                 expire;
  logic [CNT_W-1:0]     step_inc;
  logic [TIMEOUT_W-1:0] tmo_inc;

  assign rd_idx     = step_reg[ADDR_W-1:0];
  assign step_match = ((sync_io ^ value_mem[rd_idx]) & mask_mem[rd_idx]) == '0;
  assign accept     = step_match && (stable_reg == STABLE_LAST);
  assign step_inc   = step_reg + CNT_W'(1);
  assign tmo_inc    = tmo_reg + TIMEOUT_W'(1);
  assign expire     = (timeout_reg != '0) && (tmo_inc == timeout_reg);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      len_reg       <= '0;
      stable_reg    <= '0;
      tmo_reg       <= '0;
      timeout_reg   <= '0;
      fail_step_reg <= '0;
      pulse_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      len_reg       <= len_next;
      stable_reg    <= stable_next;
      tmo_reg       <= tmo_next;
      timeout_reg   <= timeout_next;
      fail_step_reg <= fail_step_next;
      pulse_reg     <= pulse_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    len_next       = len_reg;
    stable_next    = stable_reg;
    tmo_next       = tmo_reg;
    timeout_next   = timeout_reg;
    fail_step_next = fail_step_reg;
    pulse_next     = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
    end else if (state_reg != ST_RUN) begin
      if (start) begin
        len_next       = seq_len;
        timeout_next   = timeout;
        step_next      = '0;
        stable_next    = '0;
        tmo_next       = '0;
        fail_step_next = '0;
        state_next     = (seq_len == '0) ? ST_PASS : ST_RUN;
      end
    end else begin
      tmo_next = tmo_inc;
      // Acceptance is checked before the timeout so a same-cycle tie passes.
      if (accept) begin
        step_next   = step_inc;
        pulse_next  = 1'b1;
        stable_next = '0;
        tmo_next    = '0;
        if (step_inc == len_reg) begin
          state_next = ST_PASS;
        end
      end else begin
        stable_next = step_match ? stable_reg + STB_W'(1) : '0;
        if (expire) begin
          state_next     = ST_FAIL;
          fail_step_next = rd_idx;
        end
      end
    end
  end

  always_comb begin
    busy        = (state_reg == ST_RUN);
    pass        = (state_reg == ST_PASS);
    fail        = (state_reg == ST_FAIL);
    fail_step   = fail_step_reg;
    step        = step_reg;
    match_pulse = pulse_reg;
  end

endmodule

// File: tb/tb_io_seq_checker.sv
// Directed and randomized checks of io_seq_checker (STABLE=1 and STABLE=3
// instances side by side) against a cycle-level behavioural model.
module tb_io_seq_checker;

  logic        CLK = 1'b0;
  logic        reset, wr_en, start, abort;
  logic [7:0]  io_in, wr_value, wr_mask;
  logic [3:0]  wr_addr;
  logic [4:0]  seq_len;
  logic [23:0] timeout;

  logic       busy1, pass1, fail1, pulse1, busy3, pass3, fail3, pulse3;
  logic [3:0] fstep1, fstep3;
  logic [4:0] step1, step3;

  always #5 CLK = ~CLK;

  io_seq_checker #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24), .STABLE(1)) dut1 (
    .CLK(CLK), .reset(reset), .io_in(io_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_value(wr_value), .wr_mask(wr_mask), .seq_len(seq_len), .timeout(timeout),
    .start(start), .abort(abort), .busy(busy1), .pass(pass1), .fail(fail1),
    .fail_step(fstep1), .step(step1), .match_pulse(pulse1));

  io_seq_checker #(.WIDTH(8), .DEPTH(16), .TIMEOUT_W(24), .STABLE(3)) dut3 (
    .CLK(CLK), .reset(reset), .io_in(io_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_value(wr_value), .wr_mask(wr_mask), .seq_len(seq_len), .timeout(timeout),
    .start(start), .abort(abort), .busy(busy3), .pass(pass3), .fail(fail3),
    .fail_step(fstep3), .step(step3), .match_pulse(pulse3));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model: index 0 tracks dut1, index 1 tracks dut3.
  logic [7:0] m_val  [2][16];
  logic [7:0] m_mask [2][16];
  bit   m_run[2], m_pass[2], m_fail[2], m_pulse[2];
  int   m_step[2], m_fstep[2], m_stab[2], m_el[2], m_len[2], m_to[2];
  logic [7:0] q0 = 8'h00, q1 = 8'h00;

  int np[2], acc4_c[2], fail_c[2], last_pulse_c[2];

  logic [7:0] seq_vals [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_edge();
    logic [7:0] seen;
    bit run_pre;
    seen = q0;  // bus value from two edges ago, as seen after synchronization
    for (int k = 0; k < 2; k++) begin
      int need = (k == 0) ? 1 : 3;
      run_pre  = m_run[k];
      m_pulse[k] = 0;
      if (reset) begin
        m_run[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_step[k] = 0; m_fstep[k] = 0;
        m_stab[k] = 0; m_el[k] = 0;
      end else if (abort) begin
        m_run[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
      end else if (!m_run[k]) begin
        if (start) begin
          m_len[k] = int'(seq_len); m_to[k] = int'(timeout);
          m_step[k] = 0; m_stab[k] = 0; m_el[k] = 0; m_fstep[k] = 0; m_fail[k] = 0;
          m_pass[k] = (m_len[k] == 0);
          m_run[k]  = (m_len[k] != 0);
        end
      end else begin
        m_el[k]++;
        if (((seen ^ m_val[k][m_step[k]]) & m_mask[k][m_step[k]]) == 8'h00) m_stab[k]++;
        else m_stab[k] = 0;
        if (m_stab[k] == need) begin
          m_step[k]++; m_pulse[k] = 1; m_stab[k] = 0; m_el[k] = 0;
          if (m_step[k] == m_len[k]) begin m_run[k] = 0; m_pass[k] = 1; end
        end else if (m_to[k] != 0 && m_el[k] == m_to[k]) begin
          m_run[k] = 0; m_fail[k] = 1; m_fstep[k] = m_step[k];
        end
      end
      if (wr_en && !run_pre) begin
        m_val[k][wr_addr] = wr_value; m_mask[k][wr_addr] = wr_mask;
      end
    end
    if (reset) begin q0 = 8'h00; q1 = 8'h00; end
    else begin q0 = q1; q1 = io_in; end
  endtask

  task automatic check_dut(input int k, input logic b, input logic p, input logic f,
                           input logic [3:0] fs, input logic [4:0] st, input logic mp);
    string s = (k == 0) ? "s1" : "s3";
    check({s, "_busy"},      32'(b),  32'(m_run[k]));
    check({s, "_pass"},      32'(p),  32'(m_pass[k]));
    check({s, "_fail"},      32'(f),  32'(m_fail[k]));
    check({s, "_fail_step"}, 32'(fs), 32'(m_fstep[k]));
    check({s, "_step"},      32'(st), 32'(m_step[k]));
    check({s, "_pulse"},     32'(mp), 32'(m_pulse[k]));
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    model_edge();
    @(negedge CLK);
    check_dut(0, busy1, pass1, fail1, fstep1, step1, pulse1);
    check_dut(1, busy3, pass3, fail3, fstep3, step3, pulse3);
    if (pulse1) begin np[0]++; last_pulse_c[0] = cyc; if (step1 == 5'd4) acc4_c[0] = cyc; end
    if (pulse3) begin np[1]++; last_pulse_c[1] = cyc; if (step3 == 5'd4) acc4_c[1] = cyc; end
    if (fail1 && fail_c[0] == 0) fail_c[0] = cyc;
    if (fail3 && fail_c[1] == 0) fail_c[1] = cyc;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      np[k] = 0; acc4_c[k] = 0; fail_c[k] = 0; last_pulse_c[k] = 0;
    end
  endtask

  task automatic write_entry(input int a, input logic [7:0] v, input logic [7:0] m);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_value = v; wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int len, input int to);
    seq_len = len[4:0]; timeout = to[23:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 12; i++) write_entry(i, seq_vals[i], 8'hFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    reset = 1'b1; wr_en = 0; start = 0; abort = 0; io_in = 0;
    wr_addr = 0; wr_value = 0; wr_mask = 0; seq_len = 0; timeout = 0;
    clear_stats();
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy1 | busy3), 0);
    check("reset_flags", 32'({pass1, fail1, pass3, fail3, pulse1, pulse3}), 0);
    check("reset_step", 32'({step1, step3, fstep1, fstep3}), 0);
    $display("txn reset: outputs at zero");

    // Full sequence, each value held 5 cycles.
    load_seq();
    clear_stats();
    do_start(12, 100);
    for (int i = 0; i < 12; i++) begin io_in = seq_vals[i]; repeat (5) tick(); end
    repeat (6) tick();
    check("seq_pulses_s1", np[0], 12);
    check("seq_pulses_s3", np[1], 12);
    check("seq_pass", 32'({pass1, pass3}), 32'h3);
    check("seq_fail", 32'({fail1, fail3}), 0);
    check("seq_step_s1", 32'(step1), 12);
    check("seq_step_s3", 32'(step3), 12);
    $display("txn sequence: pulses %0d/%0d step %0d", np[0], np[1], step1);

    // Entry 4 (0x05) never shows up: timeout 100 cycles after 4th acceptance.
    do_abort();
    io_in = 8'h00;
    clear_stats();
    do_start(12, 100);
    for (int i = 0; i < 4; i++) begin io_in = seq_vals[i]; repeat (5) tick(); end
    io_in = 8'h00;
    for (int i = 0; i < 250 && !(fail1 && fail3); i++) tick();
    check("tmo_fail_s1", 32'(fail1), 1);
    check("tmo_fail_s3", 32'(fail3), 1);
    check("tmo_fstep_s1", 32'(fstep1), 4);
    check("tmo_fstep_s3", 32'(fstep3), 4);
    check("tmo_delay_s1", fail_c[0] - acc4_c[0], 100);
    check("tmo_delay_s3", fail_c[1] - acc4_c[1], 100);
    $display("txn timeout: delay %0d/%0d fail_step %0d", fail_c[0] - acc4_c[0],
             fail_c[1] - acc4_c[1], fstep1);

    // Glitch filtering with STABLE=3.
    do_abort();
    write_entry(0, 8'h3C, 8'hFF);
    io_in = 8'h00;
    do_start(1, 0);
    tick(); tick();
    clear_stats();
    io_in = 8'h3C; tick(); tick();
    io_in = 8'h00; tick(); tick(); tick();
    check("glitch_ignored_s3", np[1], 0);
    io_in = 8'h3C;
    e = cyc + 1;
    for (int i = 0; i < 12 && np[1] == 0; i++) tick();
    check("glitch_accept_count_s3", np[1], 1);
    check("glitch_latency_s3", last_pulse_c[1] - e, 4);
    check("glitch_pass_s3", 32'(pass3), 1);
    $display("txn glitch: latency %0d", last_pulse_c[1] - e);

    // Masked compare and all-don't-care entry.
    do_abort();
    write_entry(0, 8'hA0, 8'hF0);
    write_entry(1, 8'h55, 8'h00);
    io_in = 8'hAF; tick(); tick();
    do_start(2, 50);
    repeat (8) tick();
    check("mask_pass", 32'({pass1, pass3}), 32'h3);
    check("mask_step", 32'({step1, step3}), 32'({5'd2, 5'd2}));
    $display("txn mask: step %0d/%0d", step1, step3);

    // Abort at step 3, then an empty sequence passes at once.
    do_abort();
    load_seq();
    io_in = 8'h00;
    do_start(12, 0);
    for (int i = 0; i < 3; i++) begin io_in = seq_vals[i]; repeat (3) tick(); end
    io_in = 8'h00; repeat (3) tick();
    check("abort_pre_step", 32'(step1), 3);
    do_abort();
    check("abort_busy", 32'({busy1, busy3}), 0);
    check("abort_flags", 32'({pass1, fail1, pass3, fail3}), 0);
    check("abort_step_hold", 32'(step1), 3);
    do_start(0, 0);
    check("empty_pass", 32'({pass1, pass3}), 32'h3);
    check("empty_step", 32'(step1), 0);
    $display("txn abort: step held %0d, empty pass %0b", 3, pass1);

    // Reset in the middle of a run.
    do_start(12, 0);
    io_in = 8'h01; repeat (3) tick();
    reset = 1'b1; tick();
    check("midreset_busy", 32'({busy1, busy3}), 0);
    check("midreset_flags", 32'({pass1, fail1, pass3, fail3, pulse1, pulse3}), 0);
    check("midreset_step", 32'({step1, step3, fstep1, fstep3}), 0);
    reset = 1'b0; tick();
    $display("txn midreset: outputs at zero");

    // Writes during RUN must not alter the table.
    write_entry(0, 8'h11, 8'hFF);
    write_entry(1, 8'h22, 8'hFF);
    write_entry(2, 8'h33, 8'hFF);
    io_in = 8'h00;
    do_start(3, 0);
    tick();
    write_entry(0, 8'h00, 8'hFF);
    repeat (5) tick();
    check("runwrite_step", 32'({step1, step3}), 0);
    check("runwrite_busy", 32'({busy1, busy3}), 32'h3);
    do_abort();
    do_start(3, 0);
    io_in = 8'h11; repeat (4) tick();
    io_in = 8'h22; repeat (4) tick();
    io_in = 8'h33; repeat (4) tick();
    repeat (4) tick();
    check("runwrite_rerun_pass", 32'({pass1, pass3}), 32'h3);
    $display("txn runwrite: rerun pass %0b/%0b", pass1, pass3);

    // Randomized sequences against the model.
    for (int it = 0; it < 25; it++) begin
      int len = $urandom_range(0, 8);
      do_abort();
      for (int i = 0; i < len; i++)
        write_entry(i, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      do_start(len, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(4, 20));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 9) < 4) io_in = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) abort = 1'b1;
        if ($urandom_range(0, 49) == 0) begin start = 1'b1; seq_len = 5'(len); end
        if ($urandom_range(0, 19) == 0) begin
          wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 7));
          wr_value = 8'($urandom_range(0, 3)); wr_mask = 8'($urandom_range(0, 255));
        end
        tick();
        abort = 1'b0; start = 1'b0; wr_en = 1'b0;
      end
      $display("txn random %0d: len %0d step %0d/%0d pass %0b/%0b fail %0b/%0b", it, len,
               step1, step3, pass1, pass3, fail1, fail3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
